// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Multiply/divide controller for the E stage of the five-stage pipeline.
// The result of mult/multu/div/divu is computed combinationally from the
// forwarded operands and captured when the operation is accepted. The block
// then reports Busy_Out for a fixed number of cycles per operation class and
// commits the captured result to HI/LO on the last busy edge. This makes the
// operation look like a multi-cycle unit to the rest of the pipeline.
//
// Handshake: Start_In is a single-cycle request. It is accepted on a rising
// edge only while the block is idle. Acceptance is implicit, so there is no
// ready output. Busy_Out high means the request was taken and no further
// request is looked at. The D stage is held off through Md_Stall_Out so that
// no MDU instruction can reach E while an operation is starting or in flight.
//
// Parameters:
//   MULT_CYCLES   busy cycles for mult/multu (>= 1)
//   DIV_CYCLES    busy cycles for div/divu   (>= 1)
//
// Ports:
//   Clk            rising-edge clock
//   Reset          asynchronous, active-high reset
//   Start_In       E-stage instruction is mult/multu/div/divu
//   Md_Op_In       00 mult, 01 multu, 10 div, 11 divu (sampled with Start_In)
//   SrcA_In        rs value: multiplicand / dividend / mthi-mtlo data
//   SrcB_In        rt value: multiplier / divisor
//   Hilo_We_In     E-stage mthi/mtlo
//   Hilo_Sel_In    0 writes LO, 1 writes HI
//   Md_Use_D_In    D-stage instruction uses the MDU or HI/LO
//   Busy_Out       registered: operation in flight
//   Hi_Out         HI register
//   Lo_Out         LO register
//   Md_Stall_Out   combinational stall request to the D stage
//   State_Dbg_Out  current FSM state (0 idle, 1 run), for checkers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start_In,
    input  logic [1:0]  Md_Op_In,
    input  logic [31:0] SrcA_In,
    input  logic [31:0] SrcB_In,
    input  logic        Hilo_We_In,
    input  logic        Hilo_Sel_In,
    input  logic        Md_Use_D_In,
    output logic        Busy_Out,
    output logic [31:0] Hi_Out,
    output logic [31:0] Lo_Out,
    output logic        Md_Stall_Out,
    output logic        State_Dbg_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_pend_q, hi_pend_d;
    logic [31:0]       lo_pend_q, lo_pend_d;
    // Clear when the captured operation was a divide by zero. In that case
    // the commit edge leaves HI/LO untouched.
    logic              pend_ok_q, pend_ok_d;

    // -------------------------------------------------------------------------
    // Combinational arithmetic on the live operands
    // -------------------------------------------------------------------------
    logic        op_is_div;
    logic        op_signed;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        divisor_zero;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_ok;

    assign op_is_div = Md_Op_In[1];
    assign op_signed = ~Md_Op_In[0];

    assign prod_s = $signed({{32{SrcA_In[31]}}, SrcA_In}) *
                    $signed({{32{SrcB_In[31]}}, SrcB_In});
    assign prod_u = {32'd0, SrcA_In} * {32'd0, SrcB_In};

    // The signed divide is done on magnitudes, and the signs are applied
    // afterwards. The magnitude of 0x80000000 is 0x80000000 when read as
    // unsigned. So 0x80000000 / -1 gives quotient 0x80000000 and remainder 0
    // without any special case.
    assign a_neg = op_signed & SrcA_In[31];
    assign b_neg = op_signed & SrcB_In[31];
    assign mag_a = a_neg ? (32'd0 - SrcA_In) : SrcA_In;
    assign mag_b = b_neg ? (32'd0 - SrcB_In) : SrcB_In;

    // A zero divisor is replaced by one so the divider never sees zero. The
    // result is discarded anyway through pend_ok.
    assign divisor_zero = (SrcB_In == 32'd0);
    assign div_b        = divisor_zero ? 32'd1 : mag_b;
    assign uquot        = mag_a / div_b;
    assign urem         = mag_a % div_b;

    // The quotient truncates toward zero. The remainder takes the sign of the
    // dividend.
    assign quot = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    assign rem  = a_neg ? (32'd0 - urem) : urem;

    always_comb begin
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        calc_ok = 1'b1;
        case (Md_Op_In)
            2'b00: begin
                calc_hi = prod_s[63:32];
                calc_lo = prod_s[31:0];
            end
            2'b01: begin
                calc_hi = prod_u[63:32];
                calc_lo = prod_u[31:0];
            end
            default: begin
                calc_hi = rem;
                calc_lo = quot;
                calc_ok = ~divisor_zero;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next-state and register update logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        pend_ok_d = pend_ok_q;

        case (state_q)
            ST_IDLE: begin
                // A start takes priority over an mthi/mtlo in the same cycle.
                // The write is dropped.
                if (Start_In) begin
                    state_d   = ST_RUN;
                    hi_pend_d = calc_hi;
                    lo_pend_d = calc_lo;
                    pend_ok_d = calc_ok;
                    cnt_d     = op_is_div ? DIV_LOAD : MULT_LOAD;
                end else if (Hilo_We_In) begin
                    if (Hilo_Sel_In) begin
                        hi_d = SrcA_In;
                    end else begin
                        lo_d = SrcA_In;
                    end
                end
            end

            ST_RUN: begin
                // Start_In and Hilo_We_In are ignored here. The operation in
                // flight simply runs to completion.
                cnt_d = cnt_q - CNT_ONE;
                // A count of zero cannot be reached in RUN. It is treated as a
                // final cycle so that a corrupted counter cannot leave the FSM
                // stuck.
                if (cnt_q == CNT_ONE || cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pend_ok_q) begin
                        hi_d = hi_pend_q;
                        lo_d = lo_pend_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Busy_Out is decoded from the single-bit state register. It therefore
    // changes only on clock edges or on reset.
    assign Busy_Out      = (state_q == ST_RUN);
    assign State_Dbg_Out = state_q;
    assign Hi_Out        = hi_q;
    assign Lo_Out        = lo_q;

    // Start_In is included so that the D-stage instruction is held in the
    // same cycle the operation is being accepted, before Busy_Out rises.
    assign Md_Stall_Out = Md_Use_D_In & (Start_In | Busy_Out);

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//
// Self-checking bench for mdu_ctrl. A behavioural model tracks the
// architectural HI/LO and the number of busy cycles left. It computes results
// with 64-bit integer arithmetic. The bench drives inputs and samples outputs
// on the falling clock edge. Md_Stall_Out is checked 1 ns after the inputs
// change.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start_In;
  logic [1:0]  Md_Op_In;
  logic [31:0] SrcA_In;
  logic [31:0] SrcB_In;
  logic        Hilo_We_In;
  logic        Hilo_Sel_In;
  logic        Md_Use_D_In;
  logic        Busy_Out;
  logic [31:0] Hi_Out;
  logic [31:0] Lo_Out;
  logic        Md_Stall_Out;
  logic        State_Dbg_Out;

  always #5 Clk = ~Clk;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start_In     (Start_In),
    .Md_Op_In     (Md_Op_In),
    .SrcA_In      (SrcA_In),
    .SrcB_In      (SrcB_In),
    .Hilo_We_In   (Hilo_We_In),
    .Hilo_Sel_In  (Hilo_Sel_In),
    .Md_Use_D_In  (Md_Use_D_In),
    .Busy_Out     (Busy_Out),
    .Hi_Out       (Hi_Out),
    .Lo_Out       (Lo_Out),
    .Md_Stall_Out (Md_Stall_Out),
    .State_Dbg_Out(State_Dbg_Out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: architectural HI/LO plus busy cycles remaining
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_ok;
  int          m_left;

  task automatic ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit ok);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    ok = 1'b1;
    hi = 32'd0;
    lo = 32'd0;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      2'b00: begin sp = sa * sb; w = sp; hi = w[63:32]; lo = w[31:0]; end
      2'b01: begin up = ua * ub; w = up; hi = w[63:32]; lo = w[31:0]; end
      2'b10: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          sq = sa / sb; sr = sa % sb;
          w = sq; lo = w[31:0];
          w = sr; hi = w[31:0];
        end
      end
      default: begin
        if (b == 32'd0) ok = 1'b0;
        else begin
          up = ua / ub; w = up; lo = w[31:0];
          up = ua % ub; w = up; hi = w[31:0];
        end
      end
    endcase
  endtask

  task automatic model_step(input bit st, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit we, input bit sel);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (st) begin
      ref_calc(op, a, b, p_hi, p_lo, p_ok);
      m_left = op[1] ? DIV_N : MULT_N;
    end else if (we) begin
      if (sel) m_hi = a;
      else     m_lo = a;
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    p_ok   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle, entered and left at a falling edge
  // ---------------------------------------------------------------------------
  logic last_stall;

  task automatic tick(input bit st, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit we, input bit sel, input bit use_d);
    Start_In    = st;
    Md_Op_In    = op;
    SrcA_In     = a;
    SrcB_In     = b;
    Hilo_We_In  = we;
    Hilo_Sel_In = sel;
    Md_Use_D_In = use_d;
    #1;
    check("stall", Md_Stall_Out, use_d & (st | (m_left > 0)));
    last_stall = Md_Stall_Out;
    model_step(st, op, a, b, we, sel);
    @(posedge Clk);
    @(negedge Clk);
    check("busy", Busy_Out, m_left > 0);
    check("state_dbg", State_Dbg_Out, m_left > 0);
    check("hi", Hi_Out, m_hi);
    check("lo", Lo_Out, m_lo);
  endtask

  task automatic idle(input int n, input bit use_d);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, use_d);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          preload;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int busy_cnt;
    int stall_cnt;

    vecs[0] = '{"mult_5_m3",   2'b00, 32'd5,        32'hFFFFFFFD, 1'b0, 32'd0,  32'd0,  MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{"multu_ff_2",  2'b01, 32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,  32'd0,  MULT_N, 32'd1,        32'hFFFFFFFE};
    vecs[2] = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 32'd0,  32'd0,  DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_7_0",    2'b11, 32'd7,        32'd0,        1'b1, 32'h11, 32'h22, DIV_N,  32'h11,       32'h22};
    vecs[4] = '{"div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,  32'd0,  DIV_N,  32'd0,        32'h80000000};

    // Reset state
    Reset = 1'b1;
    Start_In = 1'b0; Md_Op_In = 2'b00; SrcA_In = 32'd0; SrcB_In = 32'd0;
    Hilo_We_In = 1'b0; Hilo_Sel_In = 1'b0; Md_Use_D_In = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy_Out, 32'd0);
    check("rst_hi", Hi_Out, 32'd0);
    check("rst_lo", Lo_Out, 32'd0);
    check("rst_stall", Md_Stall_Out, 32'd0);
    Reset = 1'b0;
    idle(2, 1'b0);

    // Table-driven operations
    foreach (vecs[v]) begin
      if (vecs[v].preload) begin
        tick(1'b0, 2'b00, vecs[v].pre_hi, 32'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 2'b00, vecs[v].pre_lo, 32'd0, 1'b1, 1'b0, 1'b0);
        check({vecs[v].name, "_pre_hi"}, Hi_Out, vecs[v].pre_hi);
        check({vecs[v].name, "_pre_lo"}, Lo_Out, vecs[v].pre_lo);
      end
      busy_cnt = 0;
      tick(1'b1, vecs[v].op, vecs[v].a, vecs[v].b, 1'b0, 1'b0, 1'b0);
      if (Busy_Out) busy_cnt++;
      for (int i = 0; i < DIV_N + 3; i++) begin
        tick(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        if (Busy_Out) busy_cnt++;
      end
      check({vecs[v].name, "_busy_cycles"}, busy_cnt, vecs[v].exp_busy);
      check({vecs[v].name, "_hi"}, Hi_Out, vecs[v].exp_hi);
      check({vecs[v].name, "_lo"}, Lo_Out, vecs[v].exp_lo);
    end

    // Stall with a dependent D-stage instruction: start cycle plus N busy cycles
    stall_cnt = 0;
    tick(1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    if (last_stall) stall_cnt++;
    for (int i = 0; i < MULT_N + 2; i++) begin
      tick(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      if (last_stall) stall_cnt++;
    end
    check("stall_cycles_use", stall_cnt, MULT_N + 1);
    check("stall_mult_lo", Lo_Out, 32'd12);

    // No dependent D-stage instruction: never stall
    stall_cnt = 0;
    tick(1'b1, 2'b10, 32'd100, 32'd9, 1'b0, 1'b0, 1'b0);
    if (last_stall) stall_cnt++;
    for (int i = 0; i < DIV_N + 2; i++) begin
      tick(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      if (last_stall) stall_cnt++;
    end
    check("stall_cycles_nouse", stall_cnt, 32'd0);
    check("div_100_9_lo", Lo_Out, 32'd11);
    check("div_100_9_hi", Hi_Out, 32'd1);

    // Illegal start and write while running are ignored
    tick(1'b1, 2'b00, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 2'b11, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 2'b00, 32'hDEAD, 32'd0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 2'b00, 32'hBEEF, 32'd0, 1'b1, 1'b0, 1'b0);
    check("illegal_hi_unchanged", Hi_Out, 32'd1);
    idle(MULT_N, 1'b0);
    check("illegal_busy_done", Busy_Out, 32'd0);
    check("illegal_hi", Hi_Out, 32'd0);
    check("illegal_lo", Lo_Out, 32'd35);

    // Start and write in the same idle cycle: the start wins
    tick(1'b1, 2'b01, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
    idle(MULT_N + 1, 1'b0);
    check("start_wins_hi", Hi_Out, 32'd0);
    check("start_wins_lo", Lo_Out, 32'd81);

    // Reset in the middle of a divide
    tick(1'b0, 2'b00, 32'hAA, 32'd0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 2'b00, 32'hBB, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 2'b10, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("pre_reset_busy", Busy_Out, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_busy", Busy_Out, 32'd0);
    check("async_rst_hi", Hi_Out, 32'd0);
    check("async_rst_lo", Lo_Out, 32'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    idle(DIV_N + 2, 1'b0);
    check("no_late_commit_hi", Hi_Out, 32'd0);
    check("no_late_commit_lo", Lo_Out, 32'd0);
    tick(1'b1, 2'b00, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    idle(MULT_N, 1'b0);
    check("post_rst_mult_lo", Lo_Out, 32'd42);
    check("post_rst_mult_busy", Busy_Out, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      bit          r_st, r_we, r_sel, r_use;
      r_op  = 2'($urandom_range(0, 3));
      r_a   = $urandom;
      r_b   = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFFFFFF;
        2: r_a = 32'h80000000;
        3: r_b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      r_st  = ($urandom_range(0, 3) == 0);
      r_we  = ($urandom_range(0, 3) == 0);
      r_sel = 1'($urandom_range(0, 1));
      r_use = 1'($urandom_range(0, 1));
      tick(r_st, r_op, r_a, r_b, r_we, r_sel, r_use);
    end
    idle(DIV_N + 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
